// File: rtl/bigfont_pkg.sv
// bigfont_pkg: glyph indices, banner geometry, banner string and FSM states for the PACMAN banner
package bigfont_pkg;
  localparam logic [2:0] GLYPH_P = 3'd0, GLYPH_A = 3'd1, GLYPH_C = 3'd2, GLYPH_M = 3'd3, GLYPH_N = 3'd4;
  localparam int GLYPH_ROWS = 64, GLYPH_W = 24, BANNER_LEN = 6;
  localparam logic [2:0] BANNER [BANNER_LEN] = '{GLYPH_P, GLYPH_A, GLYPH_C, GLYPH_M, GLYPH_A, GLYPH_N};
  typedef enum logic [1:0] {S_IDLE, S_REVEAL, S_BLINK} state_t;
endpackage

// File: rtl/bigfont_slot_decode.sv
// bigfont_slot_decode: banner column -> letter slot and bit column (i_col in, o_slot/o_bitcol out)
module bigfont_slot_decode
  import bigfont_pkg::*;
(
  input  logic [7:0] i_col,
  output logic [2:0] o_slot,
  output logic [4:0] o_bitcol
);
  logic [7:0] w_base;
  assign o_slot = i_col < 8'(GLYPH_W)     ? 3'd0 :
                  i_col < 8'(GLYPH_W * 2) ? 3'd1 :
                  i_col < 8'(GLYPH_W * 3) ? 3'd2 :
                  i_col < 8'(GLYPH_W * 4) ? 3'd3 :
                  i_col < 8'(GLYPH_W * 5) ? 3'd4 : 3'd5;
  assign w_base   = 8'(o_slot) * 8'(GLYPH_W);
  assign o_bitcol = 5'(i_col - w_base);
endmodule

// File: rtl/bigfont_banner_ctrl.sv
// bigfont_banner_ctrl: maps DrawX/DrawY to big-font ROM address, 2-cycle pixel_on with reveal/blink animation; done while blinking
module bigfont_banner_ctrl
  import bigfont_pkg::*;
#(
  parameter int X0 = 208,
  parameter int Y0 = 96,
  parameter int REVEAL_FRAMES = 15,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        pixel_on,
  output logic        done
);
  localparam logic [9:0] LX0 = 10'(X0), LX1 = 10'(X0 + BANNER_LEN * GLYPH_W);
  localparam logic [9:0] LY0 = 10'(Y0), LY1 = 10'(Y0 + GLYPH_ROWS);
  logic [7:0] w_col;
  logic [5:0] w_row;
  logic [2:0] w_slot, r_slot;
  logic [4:0] w_bitcol, r_bitcol;
  logic       w_in_box, r_in_box;
  state_t     r_state, w_state;
  logic [4:0] r_frame_cnt, w_frame_cnt;
  logic [2:0] r_letters, w_letters;
  logic       r_blink_vis, w_blink_vis;
  assign w_col    = 8'(DrawX - LX0);
  assign w_row    = 6'(DrawY - LY0);
  assign w_in_box = DrawX >= LX0 && DrawX < LX1 && DrawY >= LY0 && DrawY < LY1;
  assign done     = r_state == S_BLINK;
  bigfont_slot_decode u_dec (.i_col(w_col), .o_slot(w_slot), .o_bitcol(w_bitcol));
  always_comb begin
    w_state     = r_state;
    w_frame_cnt = r_frame_cnt;
    w_letters   = r_letters;
    w_blink_vis = r_blink_vis;
    if (!enable) begin
      w_state     = S_IDLE;
      w_frame_cnt = '0;
      w_letters   = '0;
      w_blink_vis = 1'b1;
    end else if (r_state == S_IDLE) begin
      w_state   = S_REVEAL;
      w_letters = 3'd1;
    end else if (frame_start) begin
      w_frame_cnt = r_frame_cnt + 5'd1;
      if (r_state == S_REVEAL && r_frame_cnt == 5'(REVEAL_FRAMES - 1)) begin
        w_frame_cnt = '0;
        if (r_letters < 3'(BANNER_LEN)) w_letters = r_letters + 3'd1;
        else begin
          w_state     = S_BLINK;
          w_blink_vis = 1'b1;
        end
      end
      if (r_state == S_BLINK && r_frame_cnt == 5'(BLINK_FRAMES - 1)) begin
        w_frame_cnt = '0;
        w_blink_vis = !r_blink_vis;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_letters   <= '0;
      r_blink_vis <= 1'b1;
      rom_addr    <= '0;
      r_slot      <= '0;
      r_bitcol    <= '0;
      r_in_box    <= 1'b0;
      pixel_on    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_frame_cnt <= w_frame_cnt;
      r_letters   <= w_letters;
      r_blink_vis <= w_blink_vis;
      rom_addr    <= w_in_box ? {BANNER[w_slot], w_row} : '0;
      r_slot      <= w_slot;
      r_bitcol    <= w_bitcol;
      r_in_box    <= w_in_box;
      // ROM MSB is the leftmost pixel; eligibility is judged against the state at this stage
      pixel_on    <= r_in_box && rom_data[5'd23 - r_bitcol] &&
                     (r_state == S_BLINK || r_slot < r_letters) && r_blink_vis;
    end
  end
endmodule

// File: doc/bigfont_banner_ctrl.md
# bigfont_banner_ctrl

Sequences lookups into the 320×24 big-font glyph ROM (five 64-row glyphs: P=0, A=1, C=2, M=3, N=4) to draw the "PACMAN" title banner on the VGA raster. It maps the current pixel to a ROM address and picks the glyph bit for that pixel. It also animates the banner: letters are revealed one per interval, then the full word blinks. It sits between the VGA controller's DrawX/DrawY and the color mapper, and drives the ROM's address port.

## Interface
- X0, 208: banner left edge, in pixels.
- Y0, 96: banner top edge, in pixels.
- REVEAL_FRAMES, 15: frames between successive letter reveals.
- BLINK_FRAMES, 30: frames per blink half-period.
- Clk  in  1  system clock; one clock domain only.
- Reset  in  1  synchronous, active-high.
- enable  in  1  level; high runs the banner, low clears it.
- frame_start  in  1  one-cycle pulse per frame.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- rom_addr  out  9  address to the big-font ROM (registered).
- rom_data  in  24  ROM row data, combinational from rom_addr.
- pixel_on  out  1  banner ink at the pixel presented 2 cycles earlier.
- done  out  1  high while in BLINK.

## Operation
- **Banner geometry**
  - Banner size: 6 slots × 24 px = 144 px wide, 64 rows tall.
  - Slot-to-glyph string: P, A, C, M, A, N, i.e. glyph indices 0, 1, 2, 3, 1, 4.
- **In-box test:** X0 ≤ DrawX < X0+144 and Y0 ≤ DrawY < Y0+64.
- **Address and bit select**
  - col = DrawX−X0; slot = col/24; bitcol = col%24; row = DrawY−Y0 (6 bits).
  - Use a comparator chain for the divide; no divider.
  - rom_addr = glyph[slot]·64 + row.
  - Ink bit = rom_data[23−bitcol]; the MSB is the leftmost pixel.
- **Outside the box:** rom_addr is driven to 0 and pixel_on is 0.
- **pixel_on** = ink bit & in_box & (slot < letters_shown) & blink_vis.
- **State machine:** IDLE, REVEAL, BLINK. Counters: frame_cnt (5 bits), letters_shown (3 bits), blink_vis (1 bit).
  - IDLE:
    - letters_shown=0, frame_cnt=0, blink_vis=1.
    - enable high → REVEAL with letters_shown=1 on the next edge.
  - REVEAL:
    - Each frame_start increments frame_cnt.
    - On a frame_start with frame_cnt==REVEAL_FRAMES−1: frame_cnt←0.
    - If letters_shown<6, letters_shown++; otherwise go to BLINK with blink_vis=1.
  - BLINK:
    - On a frame_start with frame_cnt==BLINK_FRAMES−1: frame_cnt←0 and blink_vis toggles.
    - All 6 slots are eligible to show.
  - enable low in any state → IDLE on the next edge, with counters cleared.
- **Boundary rules**
  - enable low together with frame_start in the same cycle: enable wins; go to IDLE with no increment.
  - Reset overrides everything, including mid-reveal.
  - frame_start while in IDLE is ignored.
  - letters_shown never exceeds 6.

## Timing
- **Pipeline stage 1 (edge t+1):**
  - Registers rom_addr, bitcol, in_box and slot from the DrawX/DrawY present at cycle t.
  - rom_data is valid combinationally in the same cycle.
- **Pipeline stage 2 (edge t+2):** registers pixel_on. Total latency is 2 cycles, fixed.
- The pipeline runs every cycle regardless of state. Only the gating terms depend on state.
- State and counter updates take effect one edge after the triggering input.
- The gating terms are sampled at stage 2.
- **Reset values:**
  - Outputs: rom_addr=0, pixel_on=0, done=0.
  - Internal: state=IDLE, frame_cnt=0, letters_shown=0, blink_vis=1.
  - All pipeline registers are cleared.
- done rises one edge after the BLINK transition and falls one edge after enable drops.

## Structure
- **Package bigfont_pkg contains:**
  - Glyph index constants: GLYPH_P..GLYPH_N.
  - GLYPH_ROWS=64, GLYPH_W=24, BANNER_LEN=6.
  - The banner string constant array, 6×3 bits.
  - The state enum typedef.
- **Sub-module bigfont_slot_decode:** combinational; col (8 bits) → slot (3 bits) and bitcol (5 bits).
- **ROM placement:** bigfont_rom is instantiated at the top level, not inside this block.

## Test plan
- **Reset:** assert Reset for 2 cycles with enable=1 → rom_addr=0, pixel_on=0, done=0, state IDLE.
- **Address map:** DrawX=X0+72, DrawY=Y0+10 (slot 3, M) → rom_addr=202 after 1 cycle.
  - DrawX=X0+100, DrawY=Y0+6 (slot 4, A) → rom_addr=70.
- **Pixel, with REVEAL_FRAMES=2 and fully revealed:**
  - DrawX=X0, DrawY=Y0+6 (P, row 6, bit 23=1) → pixel_on=1 two cycles later.
  - DrawX=X0+20, same row (bit 3=0) → pixel_on=0.
  - DrawX=X0+144 → pixel_on=0 and rom_addr=0.
- **Reveal:** enable high, then 2 frame_start pulses → letters_shown=2.
  - Ink in slot 2 stays 0 until 4 pulses have occurred.
  - done rises after pulse 12.
- **Blink (BLINK_FRAMES=2):** in BLINK, pixel_on at an ink pixel alternates every 2 frame_start pulses.
- **Abort:** drop enable in the same cycle as a frame_start mid-reveal → IDLE next edge, letters_shown=0, pixel_on=0 within 2 cycles.
  - Re-raising enable restarts the reveal at 1 letter.
